// File: rtl/huc6280_timer_irq.sv
// HuC6280 on-chip interval timer ($0C00-$0C01) and interrupt controller ($1402-$1403).
// Bus responder with registered read data; the interrupt outputs are combinational from state and inputs.
module huc6280_timer_irq #(
  parameter int unsigned PRESCALE = 1024,
  parameter int unsigned PS_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic [10:0] addr,
  input  logic        we,
  input  logic [7:0]  dIn,
  output logic [7:0]  dOut,
  input  logic        irq1_in,
  input  logic        irq2_in,
  output logic        irq_tim,
  output logic        irq1,
  output logic        irq2
);

  // Only AB[10:0] reach this block, so $0C0x and $140x share the 0x40x offsets.
  // The four registers still land on distinct offsets.
  localparam logic [10:0] ADDR_CNT  = 11'h400;  // $0C00
  localparam logic [10:0] ADDR_EN   = 11'h401;  // $0C01
  localparam logic [10:0] ADDR_MASK = 11'h402;  // $1402
  localparam logic [10:0] ADDR_ACK  = 11'h403;  // $1403

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [6:0]      counter;
  logic [6:0]      reload;
  logic            enable;
  logic [PS_W-1:0] prescaler;
  logic [2:0]      mask;
  logic            tiq_pend;

  logic            wr;
  logic            rd;
  logic            wr_cnt;
  logic            wr_en;
  logic            wr_mask;
  logic            wr_ack;
  logic [7:0]      rd_data;
  logic            run;
  logic            tick;
  logic            enable_edge;
  logic            underflow;
  logic            unused_bits;

  assign unused_bits = dIn[7];

  assign wr      = cs & we;
  assign rd      = cs & ~we;
  assign wr_cnt  = wr & (addr == ADDR_CNT);
  assign wr_en   = wr & (addr == ADDR_EN);
  assign wr_mask = wr & (addr == ADDR_MASK);
  assign wr_ack  = wr & (addr == ADDR_ACK);

  // NOTE: rd_data gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    rd_data = 8'hFF;
    case (addr)
      ADDR_CNT:  rd_data = {1'b0, counter};
      ADDR_EN:   rd_data = {7'b0, enable};
      ADDR_MASK: rd_data = {5'b0, mask};
      ADDR_ACK:  rd_data = {5'b0, tiq_pend, irq1_in, irq2_in};
      default:   rd_data = 8'hFF;
    endcase
  end

  // A disable write on the same edge as a tick suppresses that tick entirely.
  assign run         = enable & ~(wr_en & ~dIn[0]);
  assign tick        = run & (prescaler == PS_LAST);
  assign enable_edge = wr_en & dIn[0] & ~enable;
  assign underflow   = tick & (counter == 7'd0);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dOut      <= 8'h00;
      counter   <= 7'd0;
      reload    <= 7'd0;
      enable    <= 1'b0;
      prescaler <= '0;
      mask      <= 3'b000;
      tiq_pend  <= 1'b0;
    end else begin
      if (wr_cnt)  reload <= dIn[6:0];
      if (wr_en)   enable <= dIn[0];
      if (wr_mask) mask   <= dIn[2:0];

      // The enable edge picks up the reload value held before this edge.
      if (enable_edge) begin
        counter   <= reload;
        prescaler <= '0;
      end else if (run) begin
        prescaler <= tick ? '0 : prescaler + PS_W'(1);
        if (tick) counter <= (counter == 7'd0) ? reload : counter - 7'd1;
      end

      if (underflow)   tiq_pend <= 1'b1;
      else if (wr_ack) tiq_pend <= 1'b0;

      if (rd) dOut <= rd_data;
    end
  end

  assign irq_tim = tiq_pend & ~mask[2];
  assign irq1    = irq1_in  & ~mask[1];
  assign irq2    = irq2_in  & ~mask[0];

endmodule

// File: doc/huc6280_timer_irq.md
Name: huc6280_timer_irq

Overview:
- Bus-responder peripheral on the CPU bus; the other end of the 65C02 core's address/data/write-enable initiator interface.
- Implements the HuC6280 on-chip interval timer at I/O offset $0C00-$0C01 and the interrupt controller at $1400-$1403.
- Drives masked interrupt requests back to the core and returns register read data on the core's data-in bus.

Parameters:
- PRESCALE, 1024, input clocks per timer decrement; legal range 2..65535.
- PS_W, 16, prescaler counter width; must satisfy 2^PS_W >= PRESCALE.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- cs  in  1  chip select from the CPU address decoder; high when the core addresses the I/O page.
- addr  in  11  I/O page offset (AB[10:0]).
- we  in  1  CPU write strobe (WE).
- dIn  in  8  write data (CPU DO).
- dOut  out  8  read data (CPU DI), registered.
- irq1_in  in  1  external IRQ1 level, active-high.
- irq2_in  in  1  external IRQ2 level, active-high.
- irq_tim  out  1  timer interrupt to the core, active-high.
- irq1  out  1  masked IRQ1 to the core, active-high.
- irq2  out  1  masked IRQ2 to the core, active-high.

Behaviour:
- Reset (async, reset=0): dOut=8'h00, counter=0, reload=0, enable=0, prescaler=0, mask=3'b000, tiq_pend=0. All outputs are low during reset, except that irq1/irq2 follow their inputs combinationally because mask=0.
- Register map (decoded when cs=1; addr compared in full):
  - $0C00: write reload<=dIn[6:0]; read {1'b0, counter}.
  - $0C01: write enable<=dIn[0]; read {7'b0, enable}.
  - $1402: write mask<=dIn[2:0] (bit0 IRQ2, bit1 IRQ1, bit2 timer); read {5'b0, mask}.
  - $1403: any write clears tiq_pend; read {5'b0, tiq_pend, irq1_in, irq2_in}.
  - Any other offset: writes are ignored; reads return 8'hFF.
- Write timing: a register updates on the rising edge where cs & we = 1.
- Read timing: when cs & ~we, dOut is loaded with the read mux on that edge, so data is valid one cycle after the address, matching synchronous-RAM timing. Otherwise dOut holds its value.
- Reading has no side effects; reading $1403 does not acknowledge.
- Enable edge: a write of enable=1 while enable=0 loads counter<=reload (the value in effect before this write) and prescaler<=0. Writing 1 while already enabled has no reload effect. Writing 0 freezes counter and prescaler.
- Timer run, while enable=1:
  - prescaler increments every clk.
  - When prescaler==PRESCALE-1 it wraps to 0 and a tick occurs.
  - On a tick with counter!=0: counter<=counter-1.
  - On a tick with counter==0: counter<=reload and tiq_pend<=1 (underflow). Period = (reload+1)*PRESCALE clocks.
- reload writes while running take effect only at the next underflow or enable edge.
- Simultaneous underflow and $1403 write on the same edge: set wins, tiq_pend=1.
- Simultaneous $0C01 disable write and tick: disable wins, no decrement, no underflow.
- Outputs, combinational from registers and inputs:
  - irq_tim = tiq_pend & ~mask[2].
  - irq1 = irq1_in & ~mask[1].
  - irq2 = irq2_in & ~mask[0].
- Masking never clears tiq_pend; unmasking re-asserts irq_tim if tiq_pend is still set.
- Reset asserted mid-count returns all state to reset values immediately; counting resumes only after a fresh enable write.
- IRQ1/IRQ2 are level-only, with no latching inside this block.

Test Plan:
- Reset values, and register readback one cycle after address:
  - Release reset, read $0C00, $0C01, $1402, $1403 -> dOut=00,00,00,00.
  - Read $0000 -> FF.
  - Write $1402=07, read -> 07.
- Timer period (PRESCALE=4):
  - Write $0C00=03, then $0C01=01.
  - irq_tim rises exactly 16 clocks after the enable write edge.
  - Counter reads 3,2,1,0 at 4-clock steps, then 3 after underflow.
- Acknowledge and collision:
  - Write $1403 -> irq_tim falls the next cycle.
  - A write to $1403 on the same edge as an underflow leaves irq_tim=1.
- Masking:
  - With tiq_pend=1, write $1402=04 -> irq_tim=0 and $1403 reads 04.
  - Write $1402=00 -> irq_tim=1.
  - irq1_in=1 with mask[1]=1 -> irq1=0.
- Enable semantics:
  - While running with counter=2, write $0C00=05 -> next underflow reloads 5.
  - Rewriting $0C01=01 does not reload.
  - $0C01=00 freezes the counter value for 100 clocks.
- Async reset mid-count: assert reset between clock edges with counter=2 -> counter, enable and irq_tim are 0 immediately, with no clock edge needed.
